nonblk_lane_bank: RTL and testbench

Parametrised successor to the single-bit conditional-update register array. Holds N lanes of W bits each. Accepts P independent write ports per cycle, with a selectable collision priority. Tracks which lanes changed and hands the changed lanes downstream as snapshots over a valid/ready interface. Used as the per-lane state bank in cosim blocks that exercise multi-write nonblocking-loop semantics.

---
 rtl/nonblk_lane_bank_if.sv | 45 ++++
 rtl/nonblk_lane_bank.sv | 118 +++++++++++
 tb/tb_nonblk_lane_bank.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nonblk_lane_bank_if.sv
// nonblk_lane_bank_if
//   Bundles the write ports, the current lane view and the snapshot
//   valid/ready channel of nonblk_lane_bank.
//
//   wr_en      [P]        per-port write enable
//   wr_lane    [P*LW]     per-port target lane (port p: [p*LW +: LW])
//   wr_data    [P*W]      per-port data        (port p: [p*W +: W])
//   snap_ready            consumer accepts the snapshot
//   arr        [N*W]      current lane contents (lane i: [i*W +: W])
//   dirty      [N]        lanes written since last capture
//   snap_valid            snapshot register occupied
//   snap_data  [N*W]      captured lane contents
//   snap_mask  [N]        lanes that were dirty at capture time
//   drop_cnt   [8]        saturating count of out-of-range writes
//
//   master: the side issuing writes and consuming snapshots.
//   slave : the lane bank itself.
interface nonblk_lane_bank_if #(
  parameter int N = 12,
  parameter int W = 8,
  parameter int P = 2
);
  localparam int LW = $clog2(N);

  logic [P-1:0]    wr_en;
  logic [P*LW-1:0] wr_lane;
  logic [P*W-1:0]  wr_data;
  logic            snap_ready;
  logic [N*W-1:0]  arr;
  logic [N-1:0]    dirty;
  logic            snap_valid;
  logic [N*W-1:0]  snap_data;
  logic [N-1:0]    snap_mask;
  logic [7:0]      drop_cnt;

  modport master (
    output wr_en, wr_lane, wr_data, snap_ready,
    input  arr, dirty, snap_valid, snap_data, snap_mask, drop_cnt
  );

  modport slave (
    input  wr_en, wr_lane, wr_data, snap_ready,
    output arr, dirty, snap_valid, snap_data, snap_mask, drop_cnt
  );
endinterface

// File: rtl/nonblk_lane_bank.sv
// nonblk_lane_bank
//   N lanes of W bits with P independent write ports per cycle. When
//   several ports hit one lane in a cycle, exactly one port's data lands
//   (highest-numbered if LAST_WINS=1, lowest-numbered otherwise). Lanes
//   written since the last capture are tracked in dirty; whenever any lane
//   is dirty and the snapshot register is free (or being drained this
//   cycle) the pre-write lane contents and the dirty mask are captured and
//   offered downstream on a valid/ready channel. Writes to lanes >= N are
//   dropped and counted in a saturating 8-bit counter.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset (clears lanes, dirty, snapshot,
//            drop counter; wins over any same-cycle handshake)
//     bus    nonblk_lane_bank_if.slave (write ports, lane view, snapshot)
module nonblk_lane_bank #(
  parameter int N         = 12,
  parameter int W         = 8,
  parameter int P         = 2,
  parameter int LAST_WINS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  nonblk_lane_bank_if.slave    bus
);
  localparam int LW = $clog2(N);

  function automatic logic in_range(input logic [LW-1:0] l);
    return int'(l) < N;
  endfunction

  // Scan order for the collision resolver: the last port scanned wins.
  function automatic int port_order(input int k);
    return (LAST_WINS != 0) ? k : (P - 1 - k);
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] a,
                                         input logic [3:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {5'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [N*W-1:0] arr_p1;
  logic [N-1:0]   dirty_p1;
  logic           vld_p1;
  logic [N*W-1:0] snap_data_p1;
  logic [N-1:0]   snap_mask_p1;
  logic [7:0]     drop_p1;

  logic [LW-1:0]  wl [P];
  logic [W-1:0]   wd [P];
  logic [P-1:0]   eff;
  logic [3:0]     drop_inc;
  logic [N*W-1:0] arr_nxt;
  logic [N-1:0]   hit;
  logic           capture;

  // ---- stage 0: port decode, collision resolve, capture decision ----
  always_comb begin
    drop_inc = '0;
    for (int p = 0; p < P; p++) begin
      wl[p]    = bus.wr_lane[p*LW +: LW];
      wd[p]    = bus.wr_data[p*W +: W];
      eff[p]   = bus.wr_en[p] & in_range(wl[p]);
      drop_inc = drop_inc + {3'b0, bus.wr_en[p] & ~in_range(wl[p])};
    end
  end

  always_comb begin
    arr_nxt = arr_p1;
    hit     = '0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < P; k++) begin
        if (eff[port_order(k)] && (wl[port_order(k)] == LW'(i))) begin
          arr_nxt[i*W +: W] = wd[port_order(k)];
          hit[i]            = 1'b1;
        end
      end
    end
  end

  // A drain and a fresh capture may coincide, giving one snapshot per cycle.
  assign capture = (|dirty_p1) & (~vld_p1 | bus.snap_ready);

  // ---- stage 1: lane state, dirty tracking, snapshot register ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      arr_p1       <= '0;
      dirty_p1     <= '0;
      vld_p1       <= 1'b0;
      snap_data_p1 <= '0;
      snap_mask_p1 <= '0;
      drop_p1      <= '0;
    end else begin
      arr_p1  <= arr_nxt;
      drop_p1 <= sat_add(drop_p1, drop_inc);
      if (capture) begin
        // Snapshot takes the pre-write contents; a lane written in the
        // capture cycle stays dirty so its new value is not lost.
        snap_data_p1 <= arr_p1;
        snap_mask_p1 <= dirty_p1;
        vld_p1       <= 1'b1;
        dirty_p1     <= hit;
      end else begin
        dirty_p1 <= dirty_p1 | hit;
        if (bus.snap_ready) vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.arr        = arr_p1;
  assign bus.dirty      = dirty_p1;
  assign bus.snap_valid = vld_p1;
  assign bus.snap_data  = snap_data_p1;
  assign bus.snap_mask  = snap_mask_p1;
  assign bus.drop_cnt   = drop_p1;
endmodule

// File: tb/tb_nonblk_lane_bank.sv
// Bench for nonblk_lane_bank (N=12, W=8, P=2). The main instance uses
// LAST_WINS=1; a second LAST_WINS=0 instance shares its inputs for the
// collision-priority check. A reference model predicts every snapshot and
// queues it; a monitor pops and compares each snapshot the DUT presents.
module tb_nonblk_lane_bank;
  localparam int N  = 12;
  localparam int W  = 8;
  localparam int P  = 2;
  localparam int LW = $clog2(N);

  typedef struct packed {
    logic [N*W-1:0] d;
    logic [N-1:0]   m;
  } snap_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  nonblk_lane_bank_if #(.N(N), .W(W), .P(P)) b1 ();
  nonblk_lane_bank_if #(.N(N), .W(W), .P(P)) b0 ();

  nonblk_lane_bank #(.N(N), .W(W), .P(P), .LAST_WINS(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );
  nonblk_lane_bank #(.N(N), .W(W), .P(P), .LAST_WINS(0)) dut_first (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );

  assign b0.wr_en      = b1.wr_en;
  assign b0.wr_lane    = b1.wr_lane;
  assign b0.wr_data    = b1.wr_data;
  assign b0.snap_ready = b1.snap_ready;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state (LAST_WINS=1 instance)
  logic [N*W-1:0] m_arr   = '0;
  logic [N-1:0]   m_dirty = '0;
  logic           m_sv    = 1'b0;
  snap_t          sq[$];

  // ---------------- stimulus helpers ----------------
  task automatic drv(input int p, input logic en, input int lane,
                     input logic [W-1:0] d);
    b1.wr_en[p]             = en;
    b1.wr_lane[p*LW +: LW]  = LW'(lane);
    b1.wr_data[p*W +: W]    = d;
  endtask

  task automatic idle();
    b1.wr_en = '0;
  endtask

  // Advance the model by one edge using the currently driven inputs, then
  // let the DUT take the same edge.
  task automatic cycle();
    logic [N*W-1:0] na;
    logic [N-1:0]   hw;
    int             ln;
    na = m_arr;
    hw = '0;
    for (int p = 0; p < P; p++) begin
      if (b1.wr_en[p]) begin
        ln = int'(b1.wr_lane[p*LW +: LW]);
        if (ln < N) begin
          na[ln*W +: W] = b1.wr_data[p*W +: W];
          hw[ln] = 1'b1;
        end
      end
    end
    if (!rst_n) begin
      m_arr   = '0;
      m_dirty = '0;
      m_sv    = 1'b0;
    end else begin
      if ((m_dirty != '0) && (!m_sv || b1.snap_ready)) begin
        sq.push_back('{d: m_arr, m: m_dirty});
        m_dirty = hw;
        m_sv    = 1'b1;
      end else begin
        m_dirty = m_dirty | hw;
        if (m_sv && b1.snap_ready) m_sv = 1'b0;
      end
      m_arr = na;
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- snapshot scoreboard monitor ----------------
  logic  mon_pv, mon_pr, mon_rn;
  snap_t mon_s;
  always @(posedge clk) begin
    mon_pv = b1.snap_valid;
    mon_pr = b1.snap_ready;
    mon_rn = rst_n;
    #2;
    if (mon_rn && b1.snap_valid && (!mon_pv || mon_pr)) begin
      n_vec++;
      if (sq.size() == 0) begin
        n_bad++;
        $display("FAIL snap_unexpected: got mask %h data %h, required no snapshot",
                 b1.snap_mask, b1.snap_data);
      end else begin
        mon_s = sq.pop_front();
        if (b1.snap_data !== mon_s.d || b1.snap_mask !== mon_s.m) begin
          n_bad++;
          $display("FAIL snap_content: got mask %h data %h, required mask %h data %h",
                   b1.snap_mask, b1.snap_data, mon_s.m, mon_s.d);
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    cycle();
    cycle();
    n_vec++;
    if (b1.arr !== '0) begin n_bad++; $display("FAIL reset_arr: got %h required 0", b1.arr); end
    n_vec++;
    if (b1.dirty !== '0 || b1.snap_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_ctrl: got dirty %h valid %b required 0/0", b1.dirty, b1.snap_valid);
    end
    n_vec++;
    if (b1.snap_data !== '0 || b1.snap_mask !== '0 || b1.drop_cnt !== 8'd0) begin
      n_bad++; $display("FAIL reset_snap: got data %h mask %h drop %0d required 0", b1.snap_data, b1.snap_mask, b1.drop_cnt);
    end
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b1;
    b1.snap_ready = 1'b0;
    drv(0, 1'b1, 0, 8'h01);
    cycle();
    idle();
    cycle();
    for (int k = 0; k < 4; k++) begin
      drv(0, 1'b1, 2*k,   8'(8'h10 + 2*k));
      drv(1, 1'b1, 2*k+1, 8'(8'h11 + 2*k));
      cycle();
    end
    idle();
    n_vec++;
    if (b1.dirty !== 12'h0FF || b1.snap_valid !== 1'b1) begin
      n_bad++; $display("FAIL mid_pre: got dirty %h valid %b required 0ff/1", b1.dirty, b1.snap_valid);
    end
    rst_n = 1'b0;
    b1.snap_ready = 1'b1;
    cycle();
    n_vec++;
    if (b1.arr !== '0 || b1.dirty !== '0 || b1.snap_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset_state: got arr %h dirty %h valid %b required 0", b1.arr, b1.dirty, b1.snap_valid);
    end
    n_vec++;
    if (b1.snap_data !== '0 || b1.snap_mask !== '0 || b1.drop_cnt !== 8'd0) begin
      n_bad++; $display("FAIL mid_reset_snap: got data %h mask %h drop %0d required 0", b1.snap_data, b1.snap_mask, b1.drop_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    b1.snap_ready = 1'b1;
    drv(0, 1'b1, 3, 8'hA5);
    cycle();
    idle();
    n_vec++;
    if (b1.arr[3*W +: W] !== 8'hA5 || b1.dirty !== 12'h008 || b1.snap_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_t1: got lane3 %h dirty %h valid %b required a5/008/0", b1.arr[3*W +: W], b1.dirty, b1.snap_valid);
    end
    cycle();
    n_vec++;
    if (b1.snap_valid !== 1'b1 || b1.snap_mask !== 12'h008 || b1.snap_data[3*W +: W] !== 8'hA5 || b1.dirty !== '0) begin
      n_bad++; $display("FAIL single_t2: got valid %b mask %h lane3 %h dirty %h required 1/008/a5/000", b1.snap_valid, b1.snap_mask, b1.snap_data[3*W +: W], b1.dirty);
    end
    cycle();
    n_vec++;
    if (b1.snap_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got valid %b required 0", b1.snap_valid); end
  endtask

  task automatic test_collision();
    drv(0, 1'b1, 5, 8'h11);
    drv(1, 1'b1, 5, 8'h22);
    cycle();
    idle();
    n_vec++;
    if (b1.arr[5*W +: W] !== 8'h22) begin n_bad++; $display("FAIL coll_last: got %h required 22", b1.arr[5*W +: W]); end
    n_vec++;
    if (b0.arr[5*W +: W] !== 8'h11) begin n_bad++; $display("FAIL coll_first: got %h required 11", b0.arr[5*W +: W]); end
    cycle();
    cycle();
  endtask

  task automatic test_backpressure();
    b1.snap_ready = 1'b1;
    drv(0, 1'b1, 9, 8'h99);
    cycle();
    idle();
    cycle();
    b1.snap_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle();
      if (k == 0) begin drv(0, 1'b1, 0, 8'h40); drv(1, 1'b1, 1, 8'h41); end
      if (k == 1) drv(0, 1'b1, 2, 8'h42);
      cycle();
      n_vec++;
      if (b1.snap_valid !== 1'b1 || b1.snap_mask !== 12'h200 || b1.snap_data[9*W +: W] !== 8'h99) begin
        n_bad++; $display("FAIL bp_hold%0d: got valid %b mask %h lane9 %h required 1/200/99", k, b1.snap_valid, b1.snap_mask, b1.snap_data[9*W +: W]);
      end
    end
    idle();
    n_vec++;
    if (b1.dirty !== 12'h007) begin n_bad++; $display("FAIL bp_dirty: got %h required 007", b1.dirty); end
    b1.snap_ready = 1'b1;
    cycle();
    n_vec++;
    if (b1.snap_valid !== 1'b1 || b1.snap_mask !== 12'h007 || b1.snap_data[23:0] !== 24'h424140) begin
      n_bad++; $display("FAIL bp_release: got valid %b mask %h low %h required 1/007/424140", b1.snap_valid, b1.snap_mask, b1.snap_data[23:0]);
    end
    cycle();
    n_vec++;
    if (b1.snap_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drain: got valid %b required 0", b1.snap_valid); end
  endtask

  task automatic test_write_during_capture();
    b1.snap_ready = 1'b1;
    drv(0, 1'b1, 7, 8'h70);
    cycle();
    drv(0, 1'b1, 7, 8'h3C);
    cycle();
    idle();
    n_vec++;
    if (b1.snap_data[7*W +: W] !== 8'h70 || b1.arr[7*W +: W] !== 8'h3C || b1.dirty[7] !== 1'b1 || b1.snap_valid !== 1'b1) begin
      n_bad++; $display("FAIL wdc: got snap7 %h arr7 %h dirty7 %b valid %b required 70/3c/1/1", b1.snap_data[7*W +: W], b1.arr[7*W +: W], b1.dirty[7], b1.snap_valid);
    end
    cycle();
    n_vec++;
    if (b1.snap_data[7*W +: W] !== 8'h3C || b1.dirty !== '0) begin
      n_bad++; $display("FAIL wdc_next: got snap7 %h dirty %h required 3c/000", b1.snap_data[7*W +: W], b1.dirty);
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    b1.snap_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drv(0, 1'b1, k + 4, 8'($urandom_range(0, 255)));
      cycle();
      if (k >= 1) begin
        n_vec++;
        if (b1.snap_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid%0d: got %b required 1", k, b1.snap_valid); end
      end
    end
    idle();
    cycle();
    cycle();
    n_vec++;
    if (b1.snap_valid !== 1'b0 || b1.dirty !== '0) begin
      n_bad++; $display("FAIL b2b_drain: got valid %b dirty %h required 0/000", b1.snap_valid, b1.dirty);
    end
  endtask

  task automatic test_out_of_range();
    logic [N*W-1:0] saved;
    b1.snap_ready = 1'b1;
    saved = b1.arr;
    drv(0, 1'b0, 15, 8'hFF);
    drv(1, 1'b0, 15, 8'hFF);
    cycle();
    n_vec++;
    if (b1.drop_cnt !== 8'd0 || b1.arr !== saved) begin
      n_bad++; $display("FAIL oor_disabled: got drop %0d arr %h required 0/%h", b1.drop_cnt, b1.arr, saved);
    end
    drv(0, 1'b1, 14, 8'h5A);
    drv(1, 1'b1, 14, 8'hA5);
    cycle();
    n_vec++;
    if (b1.drop_cnt !== 8'd2) begin n_bad++; $display("FAIL oor_first: got drop %0d required 2", b1.drop_cnt); end
    for (int k = 0; k < 199; k++) begin
      drv(0, 1'b1, 14, 8'($urandom_range(0, 255)));
      drv(1, 1'b1, 14, 8'($urandom_range(0, 255)));
      cycle();
    end
    idle();
    n_vec++;
    if (b1.drop_cnt !== 8'd255 || b0.drop_cnt !== 8'd255) begin
      n_bad++; $display("FAIL oor_sat: got drop %0d/%0d required 255", b1.drop_cnt, b0.drop_cnt);
    end
    n_vec++;
    if (b1.arr !== saved || b1.dirty !== '0) begin
      n_bad++; $display("FAIL oor_arr: got arr %h dirty %h required %h/000", b1.arr, b1.dirty, saved);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    b1.snap_ready = 1'b0;
    b1.wr_en      = '0;
    b1.wr_lane    = '0;
    b1.wr_data    = '0;
    test_reset();
    test_reset_mid();
    test_single_write();
    test_collision();
    test_backpressure();
    test_write_during_capture();
    test_back_to_back();
    test_out_of_range();
    idle();
    b1.snap_ready = 1'b1;
    cycle();
    cycle();
    cycle();
    n_vec++;
    if (sq.size() != 0) begin n_bad++; $display("FAIL snap_missing: got %0d undelivered snapshots required 0", sq.size()); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
